instr_fetch_unit: RTL and testbench

Read-side initiator for `register_file`: generates a program counter, issues `rd` and `address` to the 16 x 20-bit register file, and captures `out_data` into a 2-entry buffer. Presents each 20-bit word with its address to the instruction decoder over a valid/ready handshake. Sits between `register_file` and the decode stage of the 8-bit processor. Supports jumps with flush and, optionally, halt-opcode detection.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit: FSM states,
// bus widths, halt opcode and the position of the opcode field in a word.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 20;

   localparam int OPC_HI = 19;
   localparam int OPC_LO = 16;
   localparam int OPC_W  = OPC_HI - OPC_LO + 1;

   localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 4'hF;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W_DEF-1:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, data} pairs between the register-file return path
// and the decoder handshake; head is held in registers so outputs are glitch-free.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [1:0]        count,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_pc,
   output logic [DATA_W-1:0] head_data
);

   logic [ADDR_W-1:0] tail_pc;
   logic [DATA_W-1:0] tail_data;

   // NOTE: the two storage slots are reset as well, so the head outputs read
   // zero out of reset instead of whatever the flops powered up with.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= 2'd0;
         head_pc   <= '0;
         head_data <= '0;
         tail_pc   <= '0;
         tail_data <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_pc   <= push_pc;
                  head_data <= push_data;
               end else begin
                  tail_pc   <= push_pc;
                  tail_data <= push_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_pc   <= tail_pc;
               head_data <= tail_data;
               count     <= count - 2'd1;
            end
            2'b11: begin
               // occupancy is unchanged; the incoming word lands behind whatever remains
               if (count == 2'd1) begin
                  head_pc   <= push_pc;
                  head_data <= push_data;
               end else begin
                  head_pc   <= tail_pc;
                  head_data <= tail_data;
                  tail_pc   <= push_pc;
                  tail_data <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_valid = (count != 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Read-side initiator for register_file: PC, FSM, issue and squash logic feeding
// a 2-entry buffer to the decoder. Optional halt-opcode detection under FETCH_HALT_EN.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
`ifdef FETCH_HALT_EN
   ,
   parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] rf_address,
   output logic              rf_rd,
   input  logic [DATA_W-1:0] rf_out_data,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   output logic              busy,
   output logic              halted
);

   fetch_state_e      state;
   logic [ADDR_W-1:0] pc;
   logic              ret_pend;
   logic [ADDR_W-1:0] ret_pc;
   logic [1:0]        count;
   logic              pop;
   logic              push;
   logic [2:0]        load;
   logic              issue;
   logic [ADDR_W-1:0] issue_addr;
   logic              halt_block;
   logic              halt_squash;

`ifdef FETCH_HALT_EN
   logic halt_buf;
   logic ret_is_halt;
   logic head_is_halt;

   assign ret_is_halt  = ret_pend && (opcode_of(rf_out_data) == HALT_OPCODE);
   assign head_is_halt = instr_valid && (opcode_of(instr_data) == HALT_OPCODE);
   assign halt_block   = halt_buf || ret_is_halt;
   // the read trailing the halt word is dropped as it moves into the return stage
   assign halt_squash  = ret_is_halt && !jump_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         halt_buf <= 1'b0;
      else if (jump_valid || (pop && head_is_halt))
         halt_buf <= 1'b0;
      else if (ret_is_halt)
         halt_buf <= 1'b1;
   end
`else
   assign halt_block  = 1'b0;
   assign halt_squash = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pop        = instr_valid && instr_ready;
      push       = ret_pend && !jump_valid;
      load       = 3'(count) + 3'(rf_rd) + 3'(ret_pend) - 3'(pop);
      issue      = 1'b0;
      issue_addr = pc;
      if (jump_valid) begin
         issue      = 1'b1;
         issue_addr = jump_addr;
      end else if (start && state != RUN) begin
         issue      = 1'b1;
         issue_addr = '0;
      end else if (state == RUN && !halt_block && load < 3'd2) begin
         issue = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         halted     <= 1'b0;
         pc         <= '0;
         rf_rd      <= 1'b0;
         rf_address <= '0;
         ret_pend   <= 1'b0;
         ret_pc     <= '0;
      end else begin
         rf_rd <= issue;
         if (issue) begin
            rf_address <= issue_addr;
            pc         <= issue_addr + ADDR_W'(1);
         end
         // a jump squashes the read currently being sampled by the register file
         ret_pend <= rf_rd && !jump_valid && !halt_squash;
         ret_pc   <= rf_address;

         if (jump_valid || (start && state != RUN)) begin
            state  <= RUN;
            busy   <= 1'b1;
            halted <= 1'b0;
         end
`ifdef FETCH_HALT_EN
         else if (state == RUN && pop && head_is_halt) begin
            state  <= HALT;
            busy   <= 1'b1;
            halted <= 1'b1;
         end
`endif
      end
   end

   fetch_buffer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_pc    (ret_pc),
      .push_data  (rf_out_data),
      .pop        (pop),
      .flush      (jump_valid),
      .count      (count),
      .head_valid (instr_valid),
      .head_pc    (instr_pc),
      .head_data  (instr_data)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 16 x 20 register file
// (one-cycle registered read). Halt scenario is compiled only with FETCH_HALT_EN.
module tb_instr_fetch_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        jump_valid;
   logic [3:0]  jump_addr;
   logic [3:0]  rf_address;
   logic        rf_rd;
   logic [19:0] rf_out_data;
   logic        instr_valid;
   logic [19:0] instr_data;
   logic [3:0]  instr_pc;
   logic        instr_ready;
   logic        busy;
   logic        halted;

   logic [19:0] mem [16];
   int vectors;
   int miscompares;

   instr_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .jump_valid  (jump_valid),
      .jump_addr   (jump_addr),
      .rf_address  (rf_address),
      .rf_rd       (rf_rd),
      .rf_out_data (rf_out_data),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .busy        (busy),
      .halted      (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) if (rf_rd) rf_out_data <= mem[rf_address];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic do_reset();
      reset = 1'b0; start = 1'b0; jump_valid = 1'b0; jump_addr = 4'd0; instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // leaves the bench at the negedge just after the edge that sampled start
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++; if (rf_rd !== 1'b0) begin miscompares++; $display("FAIL rst_rf_rd: got %b want 0", rf_rd); end
      vectors++; if (rf_address !== 4'd0) begin miscompares++; $display("FAIL rst_rf_address: got %0d want 0", rf_address); end
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
      vectors++; if (instr_data !== 20'h0) begin miscompares++; $display("FAIL rst_instr_data: got %h want 0", instr_data); end
      vectors++; if (instr_pc !== 4'd0) begin miscompares++; $display("FAIL rst_instr_pc: got %0d want 0", instr_pc); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted); end
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++; if (rf_rd !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_fetch: got rf_rd=%b busy=%b want 0/0", rf_rd, busy); end
      end
   endtask

   task automatic test_stream();
      int n;
      do_reset();
      instr_ready = 1'b1;
      pulse_start();
      vectors++; if (rf_rd !== 1'b1 || rf_address !== 4'd0) begin miscompares++; $display("FAIL stream_first_issue: got rd=%b addr=%0d want 1/0", rf_rd, rf_address); end
      vectors++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL stream_e0: got valid=%b busy=%b want 0/1", instr_valid, busy); end
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL stream_e1_valid: got %b want 0", instr_valid); end
      @(negedge clk);
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL stream_latency: got valid=%b want 1", instr_valid); end
      n = 0;
      for (int c = 0; c < 60 && n < 10; c++) begin
         if (instr_valid) begin
            vectors++;
            if (instr_pc !== 4'(n) || instr_data !== 20'(n + 1)) begin
               miscompares++;
               $display("FAIL stream_word[%0d]: got pc=%0d data=%0d want pc=%0d data=%0d", n, instr_pc, instr_data, n, n + 1);
            end
            n++;
         end
         if (n < 10) @(negedge clk);
      end
      vectors++; if (n !== 10) begin miscompares++; $display("FAIL stream_count: got %0d words want 10", n); end
   endtask

   task automatic test_backpressure();
      int rd_cnt;
      int n;
      do_reset();
      instr_ready = 1'b0;
      pulse_start();
      rd_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         if (rf_rd) rd_cnt++;
         if (c >= 2) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 4'd0 || instr_data !== 20'd1) begin
               miscompares++;
               $display("FAIL stall_head[%0d]: got v=%b pc=%0d data=%0d want 1/0/1", c, instr_valid, instr_pc, instr_data);
            end
         end
         if (c < 5) @(negedge clk);
      end
      vectors++; if (rd_cnt !== 2) begin miscompares++; $display("FAIL stall_rd_count: got %0d want 2", rd_cnt); end
      instr_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 8; c++) begin
         if (instr_valid) begin
            vectors++;
            if (instr_pc !== 4'(n) || instr_data !== 20'(n + 1)) begin
               miscompares++;
               $display("FAIL release_word[%0d]: got pc=%0d data=%0d want pc=%0d data=%0d", n, instr_pc, instr_data, n, n + 1);
            end
            n++;
         end
         @(negedge clk);
      end
      vectors++; if (n !== 8) begin miscompares++; $display("FAIL release_count: got %0d words want 8", n); end
   endtask

   task automatic test_jump();
      logic found;
      int seen3;
      int seen10;
      int n;
      do_reset();
      instr_ready = 1'b1;
      pulse_start();
      found = 1'b0;
      seen3 = 0;
      for (int c = 0; c < 30 && !found; c++) begin
         if (rf_rd && rf_address == 4'd3) found = 1'b1;
         else @(negedge clk);
      end
      vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL jump_wait_rd3: got %b want 1", found); end
      jump_valid = 1'b1; jump_addr = 4'd7;
      @(negedge clk);
      jump_valid = 1'b0;
      vectors++; if (rf_rd !== 1'b1 || rf_address !== 4'd7) begin miscompares++; $display("FAIL jump_issue: got rd=%b addr=%0d want 1/7", rf_rd, rf_address); end
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL jump_flush: got valid=%b want 0", instr_valid); end
      @(negedge clk);
      if (instr_valid && instr_pc == 4'd3) seen3++;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL jump_ej1: got valid=%b want 0", instr_valid); end
      @(negedge clk);
      vectors++;
      if (instr_valid !== 1'b1 || instr_pc !== 4'd7 || instr_data !== 20'd8) begin
         miscompares++;
         $display("FAIL jump_target: got v=%b pc=%0d data=%0d want 1/7/8", instr_valid, instr_pc, instr_data);
      end
      // continue to pc 10, then jump while that head is being popped
      n = 7;
      seen10 = 0;
      for (int c = 0; c < 40 && !(instr_valid && instr_pc == 4'd10); c++) begin
         if (instr_valid) begin
            if (instr_pc == 4'd3) seen3++;
            vectors++;
            if (instr_pc !== 4'(n) || instr_data !== 20'(n + 1)) begin
               miscompares++;
               $display("FAIL jump_follow[%0d]: got pc=%0d data=%0d want pc=%0d", n, instr_pc, instr_data, n);
            end
            n++;
         end
         @(negedge clk);
      end
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 4'd10 || instr_data !== 20'd11) begin miscompares++; $display("FAIL jump_pop_head: got v=%b pc=%0d data=%0d want 1/10/11", instr_valid, instr_pc, instr_data); end
      seen10 = 1;
      jump_valid = 1'b1; jump_addr = 4'd2;
      @(negedge clk);
      jump_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         if (instr_valid && instr_pc == 4'd10) seen10++;
         @(negedge clk);
      end
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 4'd2 || instr_data !== 20'd3) begin miscompares++; $display("FAIL jump_pop_target: got v=%b pc=%0d data=%0d want 1/2/3", instr_valid, instr_pc, instr_data); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (instr_valid && instr_pc == 4'd10) seen10++;
      end
      vectors++; if (seen10 !== 1) begin miscompares++; $display("FAIL jump_pop_once: got pc10 seen %0d times want 1", seen10); end
      vectors++; if (seen3 !== 0) begin miscompares++; $display("FAIL jump_squash: got pc3 seen %0d times want 0", seen3); end
   endtask

   task automatic test_wrap();
      int n;
      logic [3:0] epc;
      do_reset();
      instr_ready = 1'b1;
      jump_valid = 1'b1; jump_addr = 4'd14;
      @(negedge clk);
      jump_valid = 1'b0;
      vectors++; if (busy !== 1'b1 || rf_rd !== 1'b1 || rf_address !== 4'd14) begin miscompares++; $display("FAIL wrap_issue: got busy=%b rd=%b addr=%0d want 1/1/14", busy, rf_rd, rf_address); end
      n = 0;
      for (int c = 0; c < 30 && n < 4; c++) begin
         if (instr_valid) begin
            epc = 4'(14 + n);
            vectors++;
            if (instr_pc !== epc || instr_data !== 20'(epc) + 20'd1) begin
               miscompares++;
               $display("FAIL wrap_word[%0d]: got pc=%0d data=%0d want pc=%0d data=%0d", n, instr_pc, instr_data, epc, epc + 5'd1);
            end
            n++;
         end
         @(negedge clk);
      end
      vectors++; if (n !== 4) begin miscompares++; $display("FAIL wrap_count: got %0d words want 4", n); end
   endtask

   task automatic test_reset_midstream();
      int rd_seen;
      do_reset();
      instr_ready = 1'b1;
      pulse_start();
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (rf_rd !== 1'b0 || rf_address !== 4'd0 || instr_valid !== 1'b0 || instr_data !== 20'h0 ||
          instr_pc !== 4'd0 || busy !== 1'b0 || halted !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got rd=%b addr=%0d v=%b data=%h pc=%0d busy=%b halted=%b want all 0",
                  rf_rd, rf_address, instr_valid, instr_data, instr_pc, busy, halted);
      end
      @(negedge clk);
      reset = 1'b1;
      rd_seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rf_rd || instr_valid) rd_seen++;
      end
      vectors++; if (rd_seen !== 0) begin miscompares++; $display("FAIL post_reset_idle: got %0d active cycles want 0", rd_seen); end
      pulse_start();
      vectors++; if (rf_rd !== 1'b1 || rf_address !== 4'd0) begin miscompares++; $display("FAIL post_reset_start: got rd=%b addr=%0d want 1/0", rf_rd, rf_address); end
   endtask

`ifdef FETCH_HALT_EN
   task automatic test_halt();
      int n;
      logic seen6;
      logic [19:0] edata;
      mem[4] = 20'hF0000;
      do_reset();
      instr_ready = 1'b1;
      pulse_start();
      n = 0;
      seen6 = 1'b0;
      for (int c = 0; c < 40 && !halted; c++) begin
         if (rf_rd && rf_address == 4'd6) seen6 = 1'b1;
         if (instr_valid) begin
            edata = (n == 4) ? 20'hF0000 : 20'(n + 1);
            vectors++;
            if (instr_pc !== 4'(n) || instr_data !== edata) begin
               miscompares++;
               $display("FAIL halt_word[%0d]: got pc=%0d data=%h want pc=%0d data=%h", n, instr_pc, instr_data, n, edata);
            end
            n++;
         end
         @(negedge clk);
      end
      vectors++; if (n !== 5) begin miscompares++; $display("FAIL halt_count: got %0d words want 5", n); end
      vectors++; if (halted !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL halt_state: got halted=%b busy=%b want 1/1", halted, busy); end
      repeat (3) begin
         @(negedge clk);
         if (rf_rd && rf_address == 4'd6) seen6 = 1'b1;
      end
      vectors++; if (seen6 !== 1'b0) begin miscompares++; $display("FAIL halt_no_rd6: got %b want 0", seen6); end
      vectors++; if (rf_rd !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_quiet: got rd=%b v=%b want 0/0", rf_rd, instr_valid); end
      mem[4] = 20'd5;
      pulse_start();
      vectors++; if (halted !== 1'b0 || rf_rd !== 1'b1 || rf_address !== 4'd0) begin miscompares++; $display("FAIL halt_restart: got halted=%b rd=%b addr=%0d want 0/1/0", halted, rf_rd, rf_address); end
   endtask
`endif

   initial begin
      vectors = 0;
      miscompares = 0;
      for (int a = 0; a < 16; a++) mem[a] = 20'(a + 1);
      reset = 1'b0; start = 1'b0; jump_valid = 1'b0; jump_addr = 4'd0; instr_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_jump();
      test_wrap();
      test_reset_midstream();
`ifdef FETCH_HALT_EN
      test_halt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
